// File: rtl/axis_arb_pkg.sv
// Shared constants and helpers for the packet round-robin stream arbiter.
// State encoding stays as plain constants so older netlists keep matching.
package axis_arb_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    // Ceiling log2, never below 1 so a grant index always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_rr_pkt_arb_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the port after
// last_grant sits at bit 0, take the lowest set bit, then rotate the index back.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    localparam int GW = clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        last_grant,
    output logic [GW-1:0]        gnt_idx,
    output logic                 gnt_any
);

    int                   start_idx;
    int                   offset;
    logic [GW-1:0]        src_idx;
    logic [NUM_PORTS-1:0] rot_req;

    always_comb begin
        start_idx = (int'(last_grant) + 1) % NUM_PORTS;
        rot_req   = '0;
        src_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            src_idx    = GW'((start_idx + i) % NUM_PORTS);
            rot_req[i] = req[src_idx];
        end
        // Scanning downward leaves the lowest set bit as the winner.
        offset = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                offset = i;
            end
        end
        gnt_any = |rot_req;
        gnt_idx = GW'((start_idx + offset) % NUM_PORTS);
    end

endmodule

// File: rtl/axis_rr_pkt_arb.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI-Stream slaves onto
// one registered master port; a grant is held from first beat through tlast.
module axis_rr_pkt_arb
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W = 8,
    localparam int GW = clog2(NUM_PORTS)
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
    output logic [NUM_PORTS-1:0]        s_axis_tready,
    input  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]        s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tlast,
    input  logic [NUM_PORTS-1:0]        port_en,
    output logic [GW-1:0]               grant_id,
    output logic                        busy,
    output logic                        pkt_done
);

    logic [0:0]           state;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        pick_idx;
    logic                 pick_any;
    logic [NUM_PORTS-1:0] req;
    logic                 out_valid;
    logic                 slave_ready;
    logic                 sel_valid;
    logic                 sel_last;
    logic [DATA_W-1:0]    sel_data;
    logic                 accept;

    // The enable mask only gates new arbitration; it is never looked at in XFER.
    assign req = s_axis_tvalid & port_en;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .gnt_idx    (pick_idx),
        .gnt_any    (pick_any)
    );

    assign sel_valid = s_axis_tvalid[grant_id];
    assign sel_last  = s_axis_tlast[grant_id];

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_id == GW'(i)) begin
                sel_data = s_axis_tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // A beat may enter whenever the output register is empty or draining now.
    assign slave_ready = !out_valid || m_axis_tready;
    assign accept      = (state == XFER) && sel_valid && slave_ready;
    assign pkt_done    = accept && sel_last;
    assign busy        = (state == XFER);
    assign m_axis_tvalid = out_valid;

    always_comb begin
        s_axis_tready = '0;
        if (state == XFER) begin
            s_axis_tready[grant_id] = slave_ready;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_PORTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (pkt_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: a new beat wins over a simultaneous drain, so valid stays up.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid    <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            m_axis_tdata <= sel_data;
            m_axis_tlast <= sel_last;
        end else if (m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
